// File: rtl/mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mul_unit
// Brief    : Two-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
//            S1 registers operand magnitudes and the result sign; S2 registers
//            the signed 64-bit product. Valid/ready handshake on both sides.
//            Optional macro MUL_UNIT_TAG_EN adds in_tag/out_tag ports that
//            carry a request tag alongside each result.
// Revision : 1.0 - initial release
// ============================================================================
module mul_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
`ifdef MUL_UNIT_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             busy
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Stage 1 state
  logic        s1_valid;
  logic [1:0]  s1_op;
  logic [31:0] s1_mag_a;
  logic [31:0] s1_mag_b;
  logic        s1_neg;

  // Stage 2 state
  logic        s2_valid;
  logic        s2_low;
  logic [63:0] s2_prod;

  // Operand decode
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // Product path and handshake
  logic [63:0] prod_mag;
  logic [63:0] prod_signed;
  logic        s2_ready;
  logic        s1_adv;
  logic        accept;

  // Decode operand signedness and take magnitudes; 0x8000_0000 maps onto itself
  always_comb begin
    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_signed = (in_op == OP_MULH);
    a_neg    = a_signed && in_a[31];
    b_neg    = b_signed && in_b[31];
    mag_a    = a_neg ? (~in_a + 32'd1) : in_a;
    mag_b    = b_neg ? (~in_b + 32'd1) : in_b;
  end

  // Unsigned 32x32 product of the S1 magnitudes, then sign restore over 64 bits
  always_comb begin
    prod_mag    = {32'd0, s1_mag_a} * {32'd0, s1_mag_b};
    prod_signed = s1_neg ? (~prod_mag + 64'd1) : prod_mag;
  end

  // Pipeline flow control: S2 frees when empty or draining, S1 moves into a free S2
  always_comb begin
    s2_ready = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_ready;
    in_ready = !s1_valid || s1_adv;
    accept   = in_valid && in_ready;
  end

  // Stage 1 register: capture op, magnitudes and sign of the result
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MUL;
      s1_mag_a <= 32'd0;
      s1_mag_b <= 32'd0;
      s1_neg   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_mag_a <= mag_a;
      s1_mag_b <= mag_b;
      s1_neg   <= a_neg ^ b_neg;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: load the product from S1, hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_low   <= 1'b0;
      s2_prod  <= 64'd0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_low   <= (s1_op == OP_MUL);
      s2_prod  <= prod_signed;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

`ifdef MUL_UNIT_TAG_EN
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;

  // Tag rides alongside its request through both stages
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_tag <= '0;
      s2_tag <= '0;
    end else begin
      if (accept) s1_tag <= in_tag;
      if (s1_adv) s2_tag <= s1_tag;
    end
  end

  assign out_tag = s2_tag;
`endif

  assign out_valid = s2_valid;
  assign out_data  = s2_low ? s2_prod[31:0] : s2_prod[63:32];
  assign busy      = s1_valid || s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_unit
// Brief    : Directed self-checking bench for mul_unit (reset, per-op vectors,
//            back-to-back streaming with stall, reset while full, tags when
//            MUL_UNIT_TAG_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

  localparam int TAG_W = 5;
  localparam int NV    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
`ifdef MUL_UNIT_TAG_EN
  logic [TAG_W-1:0] in_tag;
  logic [TAG_W-1:0] out_tag;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0]  v_op  [NV];
  logic [31:0] v_a   [NV];
  logic [31:0] v_b   [NV];
  logic [31:0] v_exp [NV];

  always #5 clk = ~clk;

  mul_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef MUL_UNIT_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Hand-computed vectors: op, a, b, expected out_data
  task automatic load_vectors();
    v_op[0]  = 2'b01; v_a[0]  = 32'h8000_0000; v_b[0]  = 32'h8000_0000; v_exp[0]  = 32'h4000_0000;
    v_op[1]  = 2'b01; v_a[1]  = 32'hFFFF_FFFF; v_b[1]  = 32'hFFFF_FFFF; v_exp[1]  = 32'h0000_0000;
    v_op[2]  = 2'b11; v_a[2]  = 32'hFFFF_FFFF; v_b[2]  = 32'hFFFF_FFFF; v_exp[2]  = 32'hFFFF_FFFE;
    v_op[3]  = 2'b00; v_a[3]  = 32'hFFFF_FFFF; v_b[3]  = 32'hFFFF_FFFF; v_exp[3]  = 32'h0000_0001;
    v_op[4]  = 2'b10; v_a[4]  = 32'hFFFF_FFFF; v_b[4]  = 32'hFFFF_FFFF; v_exp[4]  = 32'hFFFF_FFFF;
    v_op[5]  = 2'b10; v_a[5]  = 32'h0000_0002; v_b[5]  = 32'h8000_0000; v_exp[5]  = 32'h0000_0001;
    v_op[6]  = 2'b00; v_a[6]  = 32'h0000_0007; v_b[6]  = 32'h0000_0006; v_exp[6]  = 32'h0000_002A;
    v_op[7]  = 2'b01; v_a[7]  = 32'hFFFF_FFFE; v_b[7]  = 32'h0000_0003; v_exp[7]  = 32'hFFFF_FFFF;
    v_op[8]  = 2'b00; v_a[8]  = 32'hFFFF_FFFE; v_b[8]  = 32'h0000_0003; v_exp[8]  = 32'hFFFF_FFFA;
    v_op[9]  = 2'b11; v_a[9]  = 32'h8000_0000; v_b[9]  = 32'h0000_0002; v_exp[9]  = 32'h0000_0001;
    v_op[10] = 2'b01; v_a[10] = 32'h7FFF_FFFF; v_b[10] = 32'h7FFF_FFFF; v_exp[10] = 32'h3FFF_FFFF;
    v_op[11] = 2'b01; v_a[11] = 32'h8000_0000; v_b[11] = 32'h7FFF_FFFF; v_exp[11] = 32'hC000_0000;
    v_op[12] = 2'b10; v_a[12] = 32'h8000_0000; v_b[12] = 32'hFFFF_FFFF; v_exp[12] = 32'h8000_0000;
    v_op[13] = 2'b01; v_a[13] = 32'hFFFF_FFFF; v_b[13] = 32'h0000_0000; v_exp[13] = 32'h0000_0000;
    v_op[14] = 2'b00; v_a[14] = 32'h0001_0000; v_b[14] = 32'h0001_0000; v_exp[14] = 32'h0000_0000;
    v_op[15] = 2'b11; v_a[15] = 32'h1234_5678; v_b[15] = 32'h0000_0010; v_exp[15] = 32'h0000_0001;
  endtask

  // Reset state, and a request offered during reset is never accepted
  task automatic test_reset();
    int stale;
    rst = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_op = v_op[0]; in_a = v_a[0]; in_b = v_b[0];
`ifdef MUL_UNIT_TAG_EN
    in_tag = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
`ifdef MUL_UNIT_TAG_EN
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
`endif
    rst = 1'b0; in_valid = 1'b0;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL reset_no_accept: got %0d busy/valid cycles expected 0", stale); end
  endtask

  // One isolated request per vector: latency 2 edges and correct product half
  task automatic test_ops();
    for (int k = 0; k < NV; k++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ops_idle_ready[%0d]: got %b expected 1", k, in_ready); end
      in_valid = 1'b1; in_op = v_op[k]; in_a = v_a[k]; in_b = v_b[k];
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ops_lat1[%0d]: got valid=%b busy=%b expected valid=0 busy=1", k, out_valid, busy); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ops_lat2[%0d]: got valid=%b expected 1", k, out_valid); end
      checks++; if (out_data !== v_exp[k]) begin errors++; $display("FAIL ops_data[%0d]: op=%b a=%h b=%h got %h expected %h", k, v_op[k], v_a[k], v_b[k], out_data, v_exp[k]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ops_drain[%0d]: got valid=%b busy=%b expected 0 0", k, out_valid, busy); end
    end
  endtask

  // Eight back-to-back requests; consumer stalls for 3 cycles mid-stream
  task automatic test_back_to_back();
    int          sent, rcv, cyc, bp_cycles, stall_cycles;
    logic        accepted_now, held_v;
    logic [31:0] held_data;
`ifdef MUL_UNIT_TAG_EN
    logic [TAG_W-1:0] held_tag;
    held_tag = '0;
`endif
    sent = 0; rcv = 0; cyc = 0; bp_cycles = 0; stall_cycles = 0;
    held_v = 1'b0; held_data = '0;
    while (rcv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_op = v_op[sent]; in_a = v_a[sent]; in_b = v_b[sent];
`ifdef MUL_UNIT_TAG_EN
        in_tag = TAG_W'(sent);
`endif
      end
      #4;
      accepted_now = in_valid && in_ready;
      if (!in_ready) bp_cycles++;
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          errors++; $display("FAIL b2b_stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, held_data);
        end
`ifdef MUL_UNIT_TAG_EN
        checks++;
        if (out_tag !== held_tag) begin errors++; $display("FAIL b2b_stall_tag: got %h expected %h", out_tag, held_tag); end
`endif
      end
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          checks++;
          if (out_data !== v_exp[rcv]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", rcv, out_data, v_exp[rcv]); end
`ifdef MUL_UNIT_TAG_EN
          checks++;
          if (out_tag !== TAG_W'(rcv)) begin errors++; $display("FAIL b2b_tag[%0d]: got %h expected %h", rcv, out_tag, TAG_W'(rcv)); end
`endif
          rcv++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1; held_data = out_data; stall_cycles++;
`ifdef MUL_UNIT_TAG_EN
          held_tag = out_tag;
`endif
        end
      end
      @(posedge clk); #1;
      if (accepted_now) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (rcv != 8) begin errors++; $display("FAIL b2b_count: got %0d results expected 8 (cycle budget)", rcv); end
    checks++; if (bp_cycles != 3) begin errors++; $display("FAIL b2b_backpressure: got %0d in_ready-low cycles expected 3", bp_cycles); end
    checks++; if (stall_cycles != 3) begin errors++; $display("FAIL b2b_stalled: got %0d stalled cycles expected 3", stall_cycles); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b valid=%b expected 0 0", busy, out_valid); end
  endtask

  // Reset with both stages full flushes everything; no stale result afterwards
  task automatic test_reset_full();
    int stale;
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_op = v_op[k]; in_a = v_a[k]; in_b = v_b[k];
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL full_state: got valid=%b busy=%b ready=%b expected 1 1 0", out_valid, busy, in_ready);
    end
    rst = 1'b1; in_op = v_op[2]; in_a = v_a[2]; in_b = v_b[2];
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_reset: got valid=%b busy=%b ready=%b expected 0 0 1", out_valid, busy, in_ready);
    end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL full_reset_data: got %h expected 00000000", out_data); end
    stale = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL full_stale: got %0d valid cycles expected 0", stale); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef MUL_UNIT_TAG_EN
    in_tag = '0;
`endif
    load_vectors();
    @(posedge clk); #1;
    test_reset();
    test_ops();
    test_back_to_back();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
